drum_step_sequencer: RTL and testbench

Pattern-driven trigger scheduler for the oneshot drum voices (snare, kick, hihat). It holds a per-step voice-mask pattern and advances through it at a programmable step period in `mclk` cycles. At each step boundary it emits single-cycle `trig` pulses to the voices enabled for that step. It sits between the PS-side control registers and the `trig` inputs of the `src_oneshot_*` modules.

---
 rtl/drum_step_sequencer.sv | 158 +++++++++++++++
 tb/tb_drum_step_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/drum_step_sequencer.sv
// Pattern-driven trigger scheduler for the oneshot drum voices.
// Optional odd-step swing delay is enabled by defining DRUM_SEQ_SWING_EN.
module drum_step_sequencer #(
  parameter  int NUM_VOICES  = 4,
  parameter  int NUM_STEPS   = 16,
  parameter  int PERIOD_BITS = 24,
  localparam int STEP_BITS   = $clog2(NUM_STEPS)
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [PERIOD_BITS-1:0] step_period,
  input  logic [STEP_BITS-1:0]   loop_last,
  input  logic                   pat_we,
  input  logic [STEP_BITS-1:0]   pat_addr,
  input  logic [NUM_VOICES-1:0]  pat_data,
`ifdef DRUM_SEQ_SWING_EN
  input  logic [PERIOD_BITS-1:0] swing,
`endif
  output logic [NUM_VOICES-1:0]  trig,
  output logic                   step_strobe,
  output logic [STEP_BITS-1:0]   step_idx,
  output logic                   wrap,
  output logic                   running
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state, state_nx;
  logic [NUM_VOICES-1:0]  pattern [NUM_STEPS];
  logic [PERIOD_BITS-1:0] tick, tick_nx, period, period_nx, p_new;
  logic [STEP_BITS-1:0]   step_nx, step_adv;
  logic [NUM_VOICES-1:0]  trig_nx;
  logic                   strobe_nx, wrap_nx, running_nx, at_last, last_tick;
`ifdef DRUM_SEQ_SWING_EN
  logic [PERIOD_BITS-1:0] swing_tick, swing_tick_nx, s_new;
  logic [NUM_VOICES-1:0]  pend, pend_nx;
`endif

  // Step period clamped to 2 and the wrap-aware next step index.
  always_comb begin
    p_new     = (step_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : step_period;
    last_tick = (tick == period - PERIOD_BITS'(1));
    at_last   = (step_idx >= loop_last);
    step_adv  = at_last ? STEP_BITS'(0) : step_idx + STEP_BITS'(1);
`ifdef DRUM_SEQ_SWING_EN
    s_new     = (swing > p_new - PERIOD_BITS'(1)) ? p_new - PERIOD_BITS'(1) : swing;
`endif
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_nx   = state;
    tick_nx    = PERIOD_BITS'(0);
    period_nx  = period;
    step_nx    = STEP_BITS'(0);
    trig_nx    = NUM_VOICES'(0);
    strobe_nx  = 1'b0;
    wrap_nx    = 1'b0;
    running_nx = 1'b0;
`ifdef DRUM_SEQ_SWING_EN
    swing_tick_nx = PERIOD_BITS'(0);
    pend_nx       = NUM_VOICES'(0);
`endif
    case (state)
      IDLE: begin
        if (run) begin
          state_nx   = RUN;
          period_nx  = p_new;
          trig_nx    = pattern[0];
          strobe_nx  = 1'b1;
          running_nx = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (!run) begin
          state_nx = IDLE;
        end else if (last_tick) begin
          running_nx = 1'b1;
          period_nx  = p_new;
          step_nx    = step_adv;
          strobe_nx  = 1'b1;
          wrap_nx    = at_last;
`ifdef DRUM_SEQ_SWING_EN
          // An odd step with nonzero swing parks its mask until tick S.
          if (step_adv[0] && (s_new != PERIOD_BITS'(0))) begin
            pend_nx       = pattern[step_adv];
            swing_tick_nx = s_new;
          end else begin
            trig_nx = pattern[step_adv];
          end
`else
          trig_nx = pattern[step_adv];
`endif
        end else begin
          running_nx = 1'b1;
          tick_nx    = tick + PERIOD_BITS'(1);
          step_nx    = step_idx;
`ifdef DRUM_SEQ_SWING_EN
          pend_nx       = pend;
          swing_tick_nx = swing_tick;
          if ((swing_tick != PERIOD_BITS'(0)) && (tick_nx == swing_tick)) begin
            trig_nx = pend;
          end else begin
            trig_nx = NUM_VOICES'(0);
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tick        <= PERIOD_BITS'(0);
      period      <= PERIOD_BITS'(2);
      step_idx    <= STEP_BITS'(0);
      trig        <= NUM_VOICES'(0);
      step_strobe <= 1'b0;
      wrap        <= 1'b0;
      running     <= 1'b0;
`ifdef DRUM_SEQ_SWING_EN
      swing_tick  <= PERIOD_BITS'(0);
      pend        <= NUM_VOICES'(0);
`endif
    end else begin
      state       <= state_nx;
      tick        <= tick_nx;
      period      <= period_nx;
      step_idx    <= step_nx;
      trig        <= trig_nx;
      step_strobe <= strobe_nx;
      wrap        <= wrap_nx;
      running     <= running_nx;
`ifdef DRUM_SEQ_SWING_EN
      swing_tick  <= swing_tick_nx;
      pend        <= pend_nx;
`endif
    end
  end

  // Pattern memory; reads above see the pre-write contents.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= NUM_VOICES'(0);
    end else if (pat_we) begin
      pattern[pat_addr] <= pat_data;
    end else begin
      pattern[pat_addr] <= pattern[pat_addr];
    end
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed self-checking bench for drum_step_sequencer (default build, no swing).
module tb_drum_step_sequencer;
  logic        mclk = 1'b0;
  logic        rst, run, pat_we;
  logic [23:0] step_period;
  logic [3:0]  loop_last, pat_addr, pat_data;
  logic [3:0]  trig;
  logic        step_strobe, wrap, running;
  logic [3:0]  step_idx;
  int          tests = 0;
  int          fails = 0;

  drum_step_sequencer dut (
    .mclk(mclk), .rst(rst), .run(run), .step_period(step_period),
    .loop_last(loop_last), .pat_we(pat_we), .pat_addr(pat_addr),
    .pat_data(pat_data), .trig(trig), .step_strobe(step_strobe),
    .step_idx(step_idx), .wrap(wrap), .running(running)
  );

  always #5 mclk = ~mclk;

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_step(input string tag, input logic [3:0] t, input logic s,
                          input logic [3:0] idx, input logic w);
    chk({tag, ".trig"}, {28'd0, trig}, {28'd0, t});
    chk({tag, ".strobe"}, {31'd0, step_strobe}, {31'd0, s});
    chk({tag, ".idx"}, {28'd0, step_idx}, {28'd0, idx});
    chk({tag, ".wrap"}, {31'd0, wrap}, {31'd0, w});
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; pat_we = 1'b0; pat_addr = 4'd0; pat_data = 4'd0;
    step_period = 24'd8; loop_last = 4'd3;
    cyc(2);
    chk_step("reset", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("reset.running", {31'd0, running}, 32'd0);
    rst = 1'b0;
    cyc(1);
    pat_we = 1'b1; pat_addr = 4'd0; pat_data = 4'b0001;
    cyc(1);
    pat_addr = 4'd2; pat_data = 4'b0110;
    cyc(1);
    pat_we = 1'b0;
    cyc(1);
    chk("idle.running", {31'd0, running}, 32'd0);

    // Basic play, P=8, loop of 4 steps
    run = 1'b1;
    cyc(1);                                   // offset 0
    chk_step("start", 4'b0001, 1'b1, 4'd0, 1'b0);
    chk("start.running", {31'd0, running}, 32'd1);
    cyc(1);                                   // 1
    chk_step("tick1", 4'd0, 1'b0, 4'd0, 1'b0);
    cyc(14);                                  // 15
    chk_step("s1end", 4'd0, 1'b0, 4'd1, 1'b0);
    cyc(1);                                   // 16
    chk_step("step2", 4'b0110, 1'b1, 4'd2, 1'b0);
    cyc(8);                                   // 24
    chk_step("step3", 4'd0, 1'b1, 4'd3, 1'b0);
    cyc(8);                                   // 32
    chk_step("wrap1", 4'b0001, 1'b1, 4'd0, 1'b1);
    cyc(1);                                   // 33
    chk_step("postwrap", 4'd0, 1'b0, 4'd0, 1'b0);

    // Period 0 clamps to 2 from the next boundary; mid-step change waits a boundary
    step_period = 24'd0;
    cyc(6);                                   // 39
    chk_step("p8hold", 4'd0, 1'b0, 4'd0, 1'b0);
    cyc(1);                                   // 40
    chk_step("clamp.s1", 4'd0, 1'b1, 4'd1, 1'b0);
    cyc(2);                                   // 42
    chk_step("clamp.s2", 4'b0110, 1'b1, 4'd2, 1'b0);
    step_period = 24'd5;
    cyc(1);                                   // 43
    chk_step("clamp.t1", 4'd0, 1'b0, 4'd2, 1'b0);
    cyc(1);                                   // 44
    chk_step("p5.s3", 4'd0, 1'b1, 4'd3, 1'b0);
    cyc(4);                                   // 48
    chk_step("p5.t4", 4'd0, 1'b0, 4'd3, 1'b0);
    cyc(1);                                   // 49
    chk_step("p5.wrap", 4'b0001, 1'b1, 4'd0, 1'b1);

    // Stop at tick 3 of step 2, then rerun
    step_period = 24'd8;
    cyc(5);                                   // 54
    chk_step("p8.s1", 4'd0, 1'b1, 4'd1, 1'b0);
    cyc(8);                                   // 62
    chk_step("p8.s2", 4'b0110, 1'b1, 4'd2, 1'b0);
    cyc(3);                                   // 65, tick 3
    run = 1'b0;
    cyc(1);
    chk_step("stop", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("stop.running", {31'd0, running}, 32'd0);
    cyc(2);
    chk_step("idle", 4'd0, 1'b0, 4'd0, 1'b0);
    run = 1'b1;
    cyc(1);                                   // R0
    chk_step("rerun", 4'b0001, 1'b1, 4'd0, 1'b0);
    chk("rerun.running", {31'd0, running}, 32'd1);

    // Write the firing step during its boundary cycle
    pat_we = 1'b1; pat_addr = 4'd0; pat_data = 4'b1000;
    cyc(1);                                   // R0+1
    pat_we = 1'b0;
    chk_step("wr.t1", 4'd0, 1'b0, 4'd0, 1'b0);
    cyc(31);                                  // R0+32
    chk_step("wr.next", 4'b1000, 1'b1, 4'd0, 1'b1);

    // Lower loop_last below the current step
    loop_last = 4'd15;
    cyc(24);                                  // R0+56
    chk_step("ll.s3", 4'd0, 1'b1, 4'd3, 1'b0);
    cyc(8);                                   // R0+64
    chk_step("ll.s4", 4'd0, 1'b1, 4'd4, 1'b0);
    cyc(16);                                  // R0+80
    chk_step("ll.s6", 4'd0, 1'b1, 4'd6, 1'b0);
    loop_last = 4'd1;
    cyc(7);                                   // R0+87
    chk_step("ll.s6end", 4'd0, 1'b0, 4'd6, 1'b0);
    cyc(1);                                   // R0+88
    chk_step("ll.wrap", 4'b1000, 1'b1, 4'd0, 1'b1);
    cyc(8);                                   // R0+96
    chk_step("ll.s1", 4'd0, 1'b1, 4'd1, 1'b0);
    cyc(8);                                   // R0+104
    chk_step("ll.wrap2", 4'b1000, 1'b1, 4'd0, 1'b1);

    // Reset mid-step clears outputs immediately
    cyc(3);
    #1 rst = 1'b1;
    #1;
    chk_step("rst.mid", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("rst.running", {31'd0, running}, 32'd0);
    run = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk_step("rst.idle", 4'd0, 1'b0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
